// File: rtl/note_to_ps2_tx.sv
// note_to_ps2_tx: device-side PS/2 keyboard emulator.
// Maps a 6-bit piano note code to its PS/2 Set-2 make code and sends it as a
// device-to-host frame (start, 8 data LSB first, odd parity, stop). A release
// sends F0, an idle gap, then the make code.
// Optional build macro: PARALLEL_MIRROR_EN adds scan_code_out/scan_code_strobe,
// a parallel copy of each byte at the end of its stop bit.
module note_to_ps2_tx #(
  parameter int CLK_DIV    = 3000,
  parameter int GAP_CYCLES = 8000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] note,
  input  logic       note_release,
  input  logic       note_valid,
  output logic       note_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       tx_done,
  output logic       invalid_note
`ifdef PARALLEL_MIRROR_EN
  ,
  output logic [7:0] scan_code_out,
  output logic       scan_code_strobe
`endif
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [3:0]  STOP_IDX = 4'd10;

  typedef enum logic [2:0] {
    IDLE,
    BIT_HI,
    BIT_LO,
    GAP,
    DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] div_cnt_reg, div_cnt_next;
  logic [3:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  scan_reg, scan_next;
  logic        release_reg, release_next;
  logic        second_reg, second_next;
  logic        invalid_reg, invalid_next;

  logic [8:0]  map_result;
  logic [7:0]  cur_byte;
  logic [15:0] frame;
  logic        div_done;
  logic        gap_done;
  logic        stop_end;

  // Note code to {valid, Set-2 make code}; anything above 0x23 is unmapped.
  function automatic logic [8:0] map_note(input logic [5:0] n);
    logic [8:0] r;
    r = 9'h000;
    case (n)
      6'h00: r = {1'b1, 8'h15};
      6'h01: r = {1'b1, 8'h1E};
      6'h02: r = {1'b1, 8'h1D};
      6'h03: r = {1'b1, 8'h26};
      6'h04: r = {1'b1, 8'h24};
      6'h05: r = {1'b1, 8'h2D};
      6'h06: r = {1'b1, 8'h2C};
      6'h07: r = {1'b1, 8'h36};
      6'h08: r = {1'b1, 8'h35};
      6'h09: r = {1'b1, 8'h3D};
      6'h0A: r = {1'b1, 8'h3C};
      6'h0B: r = {1'b1, 8'h43};
      6'h0C: r = {1'b1, 8'h46};
      6'h0D: r = {1'b1, 8'h44};
      6'h0E: r = {1'b1, 8'h45};
      6'h0F: r = {1'b1, 8'h4D};
      6'h10: r = {1'b1, 8'h1A};
      6'h11: r = {1'b1, 8'h1B};
      6'h12: r = {1'b1, 8'h22};
      6'h13: r = {1'b1, 8'h23};
      6'h14: r = {1'b1, 8'h21};
      6'h15: r = {1'b1, 8'h2B};
      6'h16: r = {1'b1, 8'h2A};
      6'h17: r = {1'b1, 8'h32};
      6'h18: r = {1'b1, 8'h33};
      6'h19: r = {1'b1, 8'h31};
      6'h1A: r = {1'b1, 8'h3B};
      6'h1B: r = {1'b1, 8'h3A};
      6'h1C: r = {1'b1, 8'h41};
      6'h1D: r = {1'b1, 8'h4B};
      6'h1E: r = {1'b1, 8'h49};
      6'h1F: r = {1'b1, 8'h4C};
      6'h20: r = {1'b1, 8'h4A};
      6'h21: r = {1'b1, 8'h52};
      6'h22: r = {1'b1, 8'h59};
      6'h23: r = {1'b1, 8'h2E};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  assign map_result = map_note(note);

  // First byte of a release is the F0 prefix; otherwise the latched make code.
  assign cur_byte = (release_reg && !second_reg) ? 8'hF0 : scan_reg;

  // Frame in transmit order from bit 0; upper padding keeps the 4-bit index in range.
  assign frame    = {5'b11111, 1'b1, ~^cur_byte, cur_byte, 1'b0};
  assign div_done = (div_cnt_reg == DIV_LAST);
  assign gap_done = (div_cnt_reg == GAP_LAST);
  assign stop_end = (state_reg == BIT_LO) && div_done && (bit_idx_reg == STOP_IDX);

  // Line and handshake outputs decoded from registered state only.
  assign note_ready   = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign tx_done      = (state_reg == DONE);
  assign invalid_note = invalid_reg;
  assign ps2_clk      = (state_reg != BIT_LO);
  assign ps2_data     = ((state_reg == BIT_HI) || (state_reg == BIT_LO)) ?
                        frame[bit_idx_reg] : 1'b1;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      div_cnt_reg <= '0;
      bit_idx_reg <= '0;
      scan_reg    <= '0;
      release_reg <= 1'b0;
      second_reg  <= 1'b0;
      invalid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
      bit_idx_reg <= bit_idx_next;
      scan_reg    <= scan_next;
      release_reg <= release_next;
      second_reg  <= second_next;
      invalid_reg <= invalid_next;
    end
  end

  // Next-state logic: acceptance, half-period timing, bit sequencing, gap.
  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    bit_idx_next = bit_idx_reg;
    scan_next    = scan_reg;
    release_next = release_reg;
    second_next  = second_reg;
    invalid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        div_cnt_next = '0;
        if (note_valid) begin
          if (map_result[8]) begin
            scan_next    = map_result[7:0];
            release_next = note_release;
            second_next  = 1'b0;
            bit_idx_next = '0;
            state_next   = BIT_HI;
          end else begin
            invalid_next = 1'b1;
          end
        end
      end
      BIT_HI: begin
        if (div_done) begin
          div_cnt_next = '0;
          state_next   = BIT_LO;
        end else begin
          div_cnt_next = div_cnt_reg + 16'd1;
        end
      end
      BIT_LO: begin
        if (div_done) begin
          div_cnt_next = '0;
          if (bit_idx_reg == STOP_IDX) begin
            if (release_reg && !second_reg) begin
              second_next  = 1'b1;
              bit_idx_next = '0;
              state_next   = GAP;
            end else begin
              state_next = DONE;
            end
          end else begin
            bit_idx_next = bit_idx_reg + 4'd1;
            state_next   = BIT_HI;
          end
        end else begin
          div_cnt_next = div_cnt_reg + 16'd1;
        end
      end
      GAP: begin
        if (gap_done) begin
          div_cnt_next = '0;
          state_next   = BIT_HI;
        end else begin
          div_cnt_next = div_cnt_reg + 16'd1;
        end
      end
      DONE: begin
        div_cnt_next = '0;
        state_next   = IDLE;
      end
      default: begin
        div_cnt_next = '0;
        state_next   = IDLE;
      end
    endcase
  end

`ifdef PARALLEL_MIRROR_EN
  logic [7:0] scan_out_reg;
  logic       strobe_reg;

  // Parallel copy of each byte, pulsed as its stop bit completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_out_reg <= '0;
      strobe_reg   <= 1'b0;
    end else begin
      strobe_reg <= stop_end;
      if (stop_end) begin
        scan_out_reg <= cur_byte;
      end
    end
  end

  assign scan_code_out    = scan_out_reg;
  assign scan_code_strobe = strobe_reg;
`else
  logic unused_stop_end;
  assign unused_stop_end = stop_end;
`endif

endmodule

// File: tb/tb_note_to_ps2_tx.sv
// Self-checking bench for note_to_ps2_tx (CLK_DIV=4, GAP_CYCLES=10).
// A negedge monitor records the serial line; a vector table drives transfers.
module tb_note_to_ps2_tx;

  localparam int CLK_DIV = 4;
  localparam int GAP     = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] note = '0;
  logic       note_release = 1'b0;
  logic       note_valid = 1'b0;
  logic       note_ready, ps2_clk, ps2_data, busy, tx_done, invalid_note;
`ifdef PARALLEL_MIRROR_EN
  logic [7:0] scan_code_out;
  logic       scan_code_strobe;
`endif

  note_to_ps2_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .note         (note),
    .note_release (note_release),
    .note_valid   (note_valid),
    .note_ready   (note_ready),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .busy         (busy),
    .tx_done      (tx_done),
    .invalid_note (invalid_note)
`ifdef PARALLEL_MIRROR_EN
    ,
    .scan_code_out    (scan_code_out),
    .scan_code_strobe (scan_code_strobe)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Line monitor: counters only ever grow, the test works with deltas.
  bit   bits[$];
  int   cyc = 0;
  int   low_cnt = 0, low_bad = 0, low_len = 0;
  int   edge_cnt = 0, glitch_cnt = 0;
  int   done_cnt = 0, inv_cnt = 0, post_bad = 0, start_bad = 0, notready_cnt = 0;
  int   start_cycle = 0, done_cycle = 0;
  int   strobe_cnt = 0;
  logic [7:0] last_strobe = '0;
  logic prev_clk = 1'b1, prev_data = 1'b1, prev_done = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_clk && !ps2_clk) begin
      bits.push_back(ps2_data);
      low_cnt = low_cnt + 1;
    end
    if (!ps2_clk) low_len = low_len + 1;
    else begin
      if (!prev_clk && low_len != CLK_DIV) low_bad = low_bad + 1;
      low_len = 0;
    end
    if (ps2_clk != prev_clk) edge_cnt = edge_cnt + 1;
    if (!ps2_clk && ps2_data != prev_data) glitch_cnt = glitch_cnt + 1;
    if (tx_done) begin
      done_cnt = done_cnt + 1;
      done_cycle = cyc;
    end
    if (prev_done && !(note_ready && !busy)) post_bad = post_bad + 1;
    if (invalid_note) inv_cnt = inv_cnt + 1;
    if (busy && !prev_busy) begin
      start_cycle = cyc;
      if (ps2_data !== 1'b0 || ps2_clk !== 1'b1) start_bad = start_bad + 1;
    end
    if (!note_ready) notready_cnt = notready_cnt + 1;
`ifdef PARALLEL_MIRROR_EN
    if (scan_code_strobe) begin
      strobe_cnt = strobe_cnt + 1;
      last_strobe = scan_code_out;
    end
`endif
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
    prev_done = tx_done;
    prev_busy = busy;
  end

  // Frames are written with bit 0 = first bit on the wire.
  typedef struct {
    logic [5:0]  note;
    logic        rel;
    int          nbytes;
    logic [10:0] f0;
    logic [10:0] f1;
    logic [7:0]  last_byte;
    int          cycles;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int idx, input int inject_at);
    vec_t v;
    int   b_bits, b_low, b_lowbad, b_edge, b_glitch, b_done, b_inv;
    int   b_post, b_start, b_nr, b_strobe, got;
    logic [10:0] fr;
    v        = vecs[idx];
    b_bits   = bits.size();
    b_low    = low_cnt;   b_lowbad = low_bad;  b_edge = edge_cnt;
    b_glitch = glitch_cnt; b_done = done_cnt;  b_inv  = inv_cnt;
    b_post   = post_bad;  b_start = start_bad; b_nr   = notready_cnt;
    b_strobe = strobe_cnt;
    @(posedge clk); #1;
    note = v.note; note_release = v.rel; note_valid = 1'b1;
    @(posedge clk); #1;
    note_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 600; k++) begin
      if (k == inject_at) begin
        note = 6'h22; note_release = 1'b0; note_valid = 1'b1;
      end else begin
        note_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (done_cnt > b_done || inv_cnt > b_inv) begin
        got = 1;
        break;
      end
    end
    note_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("complete", got, 1);
    chk("bit_count", bits.size() - b_bits, 11 * v.nbytes);
    chk("low_pulses", low_cnt - b_low, 11 * v.nbytes);
    chk("low_width", low_bad - b_lowbad, 0);
    chk("data_while_low", glitch_cnt - b_glitch, 0);
    chk("tx_done_count", done_cnt - b_done, (v.nbytes > 0) ? 1 : 0);
    chk("invalid_count", inv_cnt - b_inv, (v.nbytes == 0) ? 1 : 0);
    chk("ready_after_done", post_bad - b_post, 0);
    chk("start_bit", start_bad - b_start, 0);
    if (v.nbytes > 0) begin
      fr = '0;
      for (int i = 0; i < 11; i++)
        if (b_bits + i < bits.size()) fr[i] = bits[b_bits + i];
      chk("frame0", int'(fr), int'(v.f0));
      chk("done_latency", done_cycle - start_cycle, v.cycles);
    end else begin
      chk("no_clk_edges", edge_cnt - b_edge, 0);
      chk("ready_held", notready_cnt - b_nr, 0);
    end
    if (v.nbytes == 2) begin
      fr = '0;
      for (int i = 0; i < 11; i++)
        if (b_bits + 11 + i < bits.size()) fr[i] = bits[b_bits + 11 + i];
      chk("frame1", int'(fr), int'(v.f1));
    end
`ifdef PARALLEL_MIRROR_EN
    chk("strobe_count", strobe_cnt - b_strobe, v.nbytes);
    if (v.nbytes > 0) chk("strobe_byte", int'(last_strobe), int'(v.last_byte));
`else
    chk("strobe_absent", strobe_cnt - b_strobe, 0);
`endif
    $display("vec %0d note=%02h rel=%0d inject=%0d bytes=%0d done=%0d inv=%0d",
             idx, v.note, v.rel, inject_at, v.nbytes, done_cnt - b_done, inv_cnt - b_inv);
  endtask

  initial begin
    int b_bits, b_done, b_inv, got;
    vecs[0] = '{6'h0E, 1'b0, 1, 11'b10010001010, 11'b0,          8'h45, 88};
    vecs[1] = '{6'h00, 1'b1, 2, 11'b11111100000, 11'b10000101010, 8'h15, 186};
    vecs[2] = '{6'h24, 1'b0, 0, 11'b0,           11'b0,          8'h00, 0};
    vecs[3] = '{6'h3F, 1'b0, 0, 11'b0,           11'b0,          8'h00, 0};
    vecs[4] = '{6'h23, 1'b0, 1, 11'b11001011100, 11'b0,          8'h2E, 88};
    vecs[5] = '{6'h22, 1'b0, 1, 11'b11010110010, 11'b0,          8'h59, 88};
    vecs[6] = '{6'h10, 1'b1, 2, 11'b11111100000, 11'b10000110100, 8'h1A, 186};
    vecs[7] = '{6'h0B, 1'b0, 1, 11'b10010000110, 11'b0,          8'h43, 88};

    // Reset held three cycles: idle lines, ready, no pulses.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ps2_clk", int'(ps2_clk), 1);
    chk("rst_ps2_data", int'(ps2_data), 1);
    chk("rst_ready", int'(note_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tx_done", int'(tx_done), 0);
    chk("rst_invalid", int'(invalid_note), 0);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    $display("reset sequence done");

    for (int i = 0; i < 8; i++) run_vec(i, -1);

    // note_valid for 0x22 pulsed mid-frame of a 0x0E press must be ignored.
    run_vec(0, 20);

    // Reset during bit 5 of a press abandons the frame silently.
    b_bits = bits.size(); b_done = done_cnt; b_inv = inv_cnt;
    @(posedge clk); #1;
    note = 6'h0E; note_release = 1'b0; note_valid = 1'b1;
    @(posedge clk); #1;
    note_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (bits.size() >= b_bits + 6) begin
        got = 1;
        break;
      end
    end
    chk("reach_bit5", got, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ps2_clk", int'(ps2_clk), 1);
    chk("midrst_ps2_data", int'(ps2_data), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(note_ready), 1);
    repeat (150) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt - b_done, 0);
    chk("midrst_no_invalid", inv_cnt - b_inv, 0);
    chk("midrst_line_quiet", int'(ps2_clk & ps2_data), 1);
    $display("mid-frame reset sequence bits_seen=%0d", bits.size() - b_bits);

    // Following press of 0x23 sends a full 0x2E frame.
    run_vec(4, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
